// File: rtl/battle_pkg.sv
// battle_pkg: shared types and constants for the battle phase sequencer.
//   battle_state_t : one-hot-ish phase encoding driven onto state_out (pixel mux select)
//   over_phase_t   : game-over animation phase
//   FADE_MAX       : fully faded GAME OVER text colour
//   fade_step()    : per-nibble saturating increment of a {r,g,b} colour
package battle_pkg;

    typedef enum logic [3:0] {
        MENU   = 4'b0000,
        PLAYER = 4'b0001,
        ENEMY  = 4'b1000,
        OVER   = 4'b1111
    } battle_state_t;

    typedef enum logic [1:0] {
        PhIdle  = 2'd0,
        PhBreak = 2'd1,
        PhFall  = 2'd2,
        PhFade  = 2'd3
    } over_phase_t;

    localparam logic [11:0] FADE_MAX = 12'hFFF;

    // Each nibble steps independently but saturates at 4'hF.
    function automatic logic [11:0] fade_step(input logic [11:0] c);
        logic [11:0] r;
        r = c;
        for (int i = 0; i < 3; i++) begin
            r[i*4 +: 4] = (c[i*4 +: 4] == 4'hF) ? 4'hF : c[i*4 +: 4] + 4'h1;
        end
        return r;
    endfunction

endpackage

// File: rtl/game_over_anim.sv
// game_over_anim: timed game-over animation owned beneath battle_sequencer.
// Runs phase 0 (idle) -> 1 (heart split) -> 2 (heart falls apart) -> 3 (text fade).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start_i         : one-cycle pulse; restarts the animation from phase 0
//   clear_i         : one-cycle pulse; returns everything to reset values and idles
//   frame_start_i   : one-cycle pulse per video frame, paces the fade
//   phase_o         : current phase 0..3
//   divided_o       : high from phase 1 onward
//   fall_valid_o    : high from phase 2 onward
//   fade_color_o    : {r,g,b} nibbles of the GAME OVER text colour
//   fade_done_o     : colour has reached FADE_MAX in phase 3
module game_over_anim
    import battle_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES   = 65000000,
    parameter int unsigned BREAK_CYCLES  = 130000000,
    parameter int unsigned FALL_CYCLES   = 130000000,
    parameter int unsigned FADE_DIV_LOG2 = 3,
    parameter int unsigned TIMER_W       = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        clear_i,
    input  logic        frame_start_i,
    output logic [1:0]  phase_o,
    output logic        divided_o,
    output logic        fall_valid_o,
    output logic [11:0] fade_color_o,
    output logic        fade_done_o
);

    localparam int unsigned FcW = (FADE_DIV_LOG2 > 0) ? FADE_DIV_LOG2 : 1;

    localparam logic [TIMER_W-1:0] IdleLast  = TIMER_W'(IDLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] BreakLast = TIMER_W'(BREAK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] FallLast  = TIMER_W'(FALL_CYCLES - 1);

    logic               active_q, active_d;
    over_phase_t        phase_q, phase_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [FcW-1:0]     frame_cnt_q, frame_cnt_d;
    logic [11:0]        color_q, color_d;
    logic               last_frame;

    // With no divider every frame is a fade step.
    assign last_frame = (FADE_DIV_LOG2 == 0) || (&frame_cnt_q);

    always_comb begin
        active_d    = active_q;
        phase_d     = phase_q;
        timer_d     = timer_q;
        frame_cnt_d = frame_cnt_q;
        color_d     = color_q;
        if (clear_i || start_i) begin
            active_d    = start_i;
            phase_d     = PhIdle;
            timer_d     = '0;
            frame_cnt_d = '0;
            color_d     = '0;
        end else if (active_q) begin
            unique case (phase_q)
                PhIdle: begin
                    if (timer_q == IdleLast) begin
                        timer_d = '0;
                        phase_d = PhBreak;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                PhBreak: begin
                    if (timer_q == BreakLast) begin
                        timer_d = '0;
                        phase_d = PhFall;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                PhFall: begin
                    if (timer_q == FallLast) begin
                        timer_d = '0;
                        phase_d = PhFade;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                PhFade: begin
                    // Timer halts here; only the frame counter advances.
                    if (frame_start_i) begin
                        frame_cnt_d = frame_cnt_q + FcW'(1);
                        if (last_frame) begin
                            color_d = fade_step(color_q);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q    <= 1'b0;
            phase_q     <= PhIdle;
            timer_q     <= '0;
            frame_cnt_q <= '0;
            color_q     <= '0;
        end else begin
            active_q    <= active_d;
            phase_q     <= phase_d;
            timer_q     <= timer_d;
            frame_cnt_q <= frame_cnt_d;
            color_q     <= color_d;
        end
    end

    assign phase_o      = phase_q;
    assign divided_o    = (phase_q != PhIdle);
    assign fall_valid_o = (phase_q == PhFall) || (phase_q == PhFade);
    assign fade_color_o = color_q;
    assign fade_done_o  = (phase_q == PhFade) && (color_q == FADE_MAX);

endmodule

// File: rtl/battle_sequencer.sv
// battle_sequencer: MENU -> PLAYER -> ENEMY round loop with wrapping turn index,
// one-cycle round reset and a sticky OVER state driving the game-over animation.
// Optional feature: define GAME_OVER_RESTART_EN to let a restart_in rising edge
// leave OVER once the fade has completed; otherwise OVER is left only by rst.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   frame_start_in    : one-cycle pulse at start of each video frame
//   menu_done_in      : menu finished (level)
//   player_done_in    : player attack finished (level)
//   enemy_done_in     : enemy pattern finished (level)
//   game_over_in      : HP reached zero (level)
//   restart_in        : restart request (optional feature only)
//   state_out         : battle_state_t encoding, selects the pixel mux
//   turn_out          : current enemy pattern index
//   round_rst_out     : one-cycle pulse resetting round sub-blocks
//   anim_phase_out    : game-over phase 0..3
//   divided_out       : heart split
//   fall_valid_out    : heart fall-apart enable
//   fade_color_out    : GAME OVER text colour {r,g,b}
//   fade_done_out     : fade finished
module battle_sequencer
    import battle_pkg::*;
#(
    parameter int unsigned NUM_TURNS     = 9,
    parameter int unsigned INIT_TURN     = 3,
    parameter int unsigned IDLE_CYCLES   = 65000000,
    parameter int unsigned BREAK_CYCLES  = 130000000,
    parameter int unsigned FALL_CYCLES   = 130000000,
    parameter int unsigned FADE_DIV_LOG2 = 3,
    parameter int unsigned TIMER_W       = 32,
    localparam int unsigned TURN_W       = (NUM_TURNS > 1) ? $clog2(NUM_TURNS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start_in,
    input  logic              menu_done_in,
    input  logic              player_done_in,
    input  logic              enemy_done_in,
    input  logic              game_over_in,
    input  logic              restart_in,
    output logic [3:0]        state_out,
    output logic [TURN_W-1:0] turn_out,
    output logic              round_rst_out,
    output logic [1:0]        anim_phase_out,
    output logic              divided_out,
    output logic              fall_valid_out,
    output logic [11:0]       fade_color_out,
    output logic              fade_done_out
);

    localparam logic [TURN_W-1:0] TurnInit = TURN_W'(INIT_TURN);
    localparam logic [TURN_W-1:0] TurnLast = TURN_W'(NUM_TURNS - 1);

    battle_state_t     state_q, state_d;
    logic [TURN_W-1:0] turn_q, turn_d;
    logic              round_rst_q, round_rst_d;

    logic menu_prev_q, player_prev_q, enemy_prev_q, over_prev_q;
    logic menu_rise, player_rise, enemy_rise, over_rise;
    logic go_over, restart_go;

    // Previous-level registers load the live inputs every cycle, reset included,
    // so a level held through rst or a round reset never produces an edge.
    always_ff @(posedge clk) begin
        menu_prev_q   <= menu_done_in;
        player_prev_q <= player_done_in;
        enemy_prev_q  <= enemy_done_in;
        over_prev_q   <= game_over_in;
    end

    assign menu_rise   = menu_done_in & ~menu_prev_q;
    assign player_rise = player_done_in & ~player_prev_q;
    assign enemy_rise  = enemy_done_in & ~enemy_prev_q;
    assign over_rise   = game_over_in & ~over_prev_q;

    assign go_over = over_rise && (state_q != OVER);

`ifdef GAME_OVER_RESTART_EN
    logic restart_prev_q;

    always_ff @(posedge clk) begin
        restart_prev_q <= restart_in;
    end

    assign restart_go = restart_in && !restart_prev_q && (state_q == OVER) && fade_done_out;
`else
    logic unused_restart;

    assign unused_restart = restart_in;
    assign restart_go     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        turn_d      = turn_q;
        round_rst_d = 1'b0;
        if (go_over) begin
            // Beats any done edge; an already-issued round reset still ends on its own.
            state_d = OVER;
        end else if (restart_go) begin
            state_d     = MENU;
            turn_d      = TurnInit;
            round_rst_d = 1'b1;
        end else if (round_rst_q) begin
            // Done edges are ignored while the round reset is on the wire.
            state_d = MENU;
        end else begin
            case (state_q)
                MENU: begin
                    if (menu_rise) state_d = PLAYER;
                end
                PLAYER: begin
                    if (player_rise) state_d = ENEMY;
                end
                ENEMY: begin
                    // Stay in ENEMY for the pulse cycle; MENU follows it.
                    if (enemy_rise) begin
                        turn_d      = (turn_q == TurnLast) ? '0 : turn_q + TURN_W'(1);
                        round_rst_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MENU;
            turn_q      <= TurnInit;
            round_rst_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            turn_q      <= turn_d;
            round_rst_q <= round_rst_d;
        end
    end

    game_over_anim #(
        .IDLE_CYCLES  (IDLE_CYCLES),
        .BREAK_CYCLES (BREAK_CYCLES),
        .FALL_CYCLES  (FALL_CYCLES),
        .FADE_DIV_LOG2(FADE_DIV_LOG2),
        .TIMER_W      (TIMER_W)
    ) u_anim (
        .clk          (clk),
        .rst          (rst),
        .start_i      (go_over),
        .clear_i      (restart_go),
        .frame_start_i(frame_start_in),
        .phase_o      (anim_phase_out),
        .divided_o    (divided_out),
        .fall_valid_o (fall_valid_out),
        .fade_color_o (fade_color_out),
        .fade_done_o  (fade_done_out)
    );

    assign state_out     = state_q;
    assign turn_out      = turn_q;
    assign round_rst_out = round_rst_q;

endmodule

// File: tb/tb_battle_sequencer.sv
// Directed bench for battle_sequencer with short animation timings.
module tb_battle_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start_in, menu_done_in, player_done_in, enemy_done_in;
    logic        game_over_in, restart_in;
    logic [3:0]  state_out;
    logic [3:0]  turn_out;
    logic        round_rst_out;
    logic [1:0]  anim_phase_out;
    logic        divided_out, fall_valid_out, fade_done_out;
    logic [11:0] fade_color_out;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    battle_sequencer #(
        .NUM_TURNS    (9),
        .INIT_TURN    (3),
        .IDLE_CYCLES  (4),
        .BREAK_CYCLES (3),
        .FALL_CYCLES  (2),
        .FADE_DIV_LOG2(3),
        .TIMER_W      (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start_in(frame_start_in),
        .menu_done_in  (menu_done_in),
        .player_done_in(player_done_in),
        .enemy_done_in (enemy_done_in),
        .game_over_in  (game_over_in),
        .restart_in    (restart_in),
        .state_out     (state_out),
        .turn_out      (turn_out),
        .round_rst_out (round_rst_out),
        .anim_phase_out(anim_phase_out),
        .divided_out   (divided_out),
        .fall_valid_out(fall_valid_out),
        .fade_color_out(fade_color_out),
        .fade_done_out (fade_done_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full round starting and ending in MENU.
    task automatic do_round();
        menu_done_in = 1'b1;   tick(); menu_done_in = 1'b0;
        player_done_in = 1'b1; tick(); player_done_in = 1'b0;
        enemy_done_in = 1'b1;  tick(); enemy_done_in = 1'b0;
        tick();
    endtask

    initial begin
        int exp_ph;
        rst = 1'b1;
        frame_start_in = 1'b0; menu_done_in = 1'b1; player_done_in = 1'b0;
        enemy_done_in = 1'b0; game_over_in = 1'b0; restart_in = 1'b0;
        tick(); tick();
        check("rst_state", state_out, 4'b0000);
        check("rst_turn", turn_out, 3);
        check("rst_round_rst", round_rst_out, 0);
        check("rst_phase", anim_phase_out, 0);
        check("rst_divided", divided_out, 0);
        check("rst_fall", fall_valid_out, 0);
        check("rst_color", fade_color_out, 12'h000);
        check("rst_fade_done", fade_done_out, 0);

        // menu_done held through reset must not fire
        rst = 1'b0; tick();
        check("held_menu_no_fire", state_out, 4'b0000);
        menu_done_in = 1'b0; tick();
        menu_done_in = 1'b1; tick();
        check("menu_to_player", state_out, 4'b0001);
        player_done_in = 1'b1; tick();
        check("player_to_enemy", state_out, 4'b1000);
        enemy_done_in = 1'b1; tick();
        check("pulse_state", state_out, 4'b1000);
        check("pulse_round_rst", round_rst_out, 1);
        check("pulse_turn", turn_out, 4);
        tick();
        check("after_pulse_state", state_out, 4'b0000);
        check("after_pulse_round_rst", round_rst_out, 0);
        tick();
        check("held_enemy_turn", turn_out, 4);
        menu_done_in = 1'b0; tick();
        menu_done_in = 1'b1; tick();
        check("menu_after_held", state_out, 4'b0001);
        check("menu_after_held_turn", turn_out, 4);

        // Finish this round with a fresh enemy edge
        menu_done_in = 1'b0; player_done_in = 1'b0; tick();
        player_done_in = 1'b1; tick(); player_done_in = 1'b0;
        check("round2_enemy", state_out, 4'b1000);
        enemy_done_in = 1'b0; tick();
        enemy_done_in = 1'b1; tick(); enemy_done_in = 1'b0;
        check("round2_turn", turn_out, 5);
        tick();
        for (int i = 0; i < 3; i++) do_round();
        check("turn_last", turn_out, 8);
        do_round();
        check("turn_wrap", turn_out, 0);
        check("wrap_state", state_out, 4'b0000);
        do_round();
        check("turn_after_wrap", turn_out, 1);

        // Game over from PLAYER
        menu_done_in = 1'b1; tick(); menu_done_in = 1'b0;
        check("pre_over_state", state_out, 4'b0001);
        game_over_in = 1'b1; tick();
        check("over_state", state_out, 4'b1111);
        check("over_ph_c1", anim_phase_out, 0);
        for (int c = 2; c <= 12; c++) begin
            tick();
            exp_ph = (c <= 4) ? 0 : (c <= 7) ? 1 : (c <= 9) ? 2 : 3;
            check($sformatf("phase_c%0d", c), anim_phase_out, exp_ph);
            check($sformatf("divided_c%0d", c), divided_out, (exp_ph >= 1) ? 1 : 0);
            check($sformatf("fall_c%0d", c), fall_valid_out, (exp_ph >= 2) ? 1 : 0);
        end
        check("over_turn_kept", turn_out, 1);
        menu_done_in = 1'b1; tick(); menu_done_in = 1'b0;
        check("over_sticky_menu", state_out, 4'b1111);
        restart_in = 1'b1; tick(); restart_in = 1'b0;
        check("early_restart_ignored", state_out, 4'b1111);
        tick();

        // Fade: one step every 8 frames
        for (int f = 1; f <= 128; f++) begin
            frame_start_in = 1'b1; tick(); frame_start_in = 1'b0;
            if (f == 7) check("fade_f7", fade_color_out, 12'h000);
            if (f == 8) check("fade_f8", fade_color_out, 12'h111);
            if (f == 119) begin
                check("fade_f119", fade_color_out, 12'hEEE);
                check("fade_done_f119", fade_done_out, 0);
            end
            if (f == 120) begin
                check("fade_f120", fade_color_out, 12'hFFF);
                check("fade_done_f120", fade_done_out, 1);
            end
            tick();
        end
        check("fade_sat", fade_color_out, 12'hFFF);
        check("fade_done_hold", fade_done_out, 1);
        check("phase_terminal", anim_phase_out, 3);

        restart_in = 1'b1; tick();
`ifdef GAME_OVER_RESTART_EN
        check("restart_state", state_out, 4'b0000);
        check("restart_turn", turn_out, 3);
        check("restart_round_rst", round_rst_out, 1);
        check("restart_color", fade_color_out, 12'h000);
        check("restart_phase", anim_phase_out, 0);
        check("restart_fade_done", fade_done_out, 0);
        tick();
        check("restart_pulse_end", round_rst_out, 0);
        check("restart_menu", state_out, 4'b0000);
`else
        check("restart_unused_state", state_out, 4'b1111);
        check("restart_unused_color", fade_color_out, 12'hFFF);
        tick();
        check("restart_unused_round_rst", round_rst_out, 0);
`endif
        restart_in = 1'b0;

        // Reset mid-OVER
        menu_done_in = 1'b1; tick(); menu_done_in = 1'b0; tick();
        game_over_in = 1'b0; tick();
        game_over_in = 1'b1; tick();
        check("over_again", state_out, 4'b1111);
        rst = 1'b1; tick();
        check("mid_rst_state", state_out, 4'b0000);
        check("mid_rst_turn", turn_out, 3);
        check("mid_rst_phase", anim_phase_out, 0);
        rst = 1'b0; tick();
        check("mid_rst_held_over", state_out, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
